// File: rtl/demux2_deser_if.sv
// demux2_deser_if: serial bit input plus per-lane word/valid/ready/overflow bundle.
interface demux2_deser_if #(parameter int W = 8);
    logic i, s, v, rdy0, rdy1;
    logic [W-1:0] q0, q1;
    logic vld0, vld1, ovf0, ovf1;
    modport master(output i, s, v, rdy0, rdy1, input q0, q1, vld0, vld1, ovf0, ovf1);
    modport slave(input i, s, v, rdy0, rdy1, output q0, q1, vld0, vld1, ovf0, ovf1);
endinterface

// File: rtl/demux2_deser.sv
// demux2_deser: two independent MSB-first deserializers fed by a lane select, each with a one-word holding register.
module demux2_deser #(parameter int W = 8) (
    input logic clk,
    input logic rst,
    demux2_deser_if.slave bus
);
    localparam int CW = $clog2(W);
    logic [1:0] rdy;
    assign rdy = {bus.rdy1, bus.rdy0};
    for (genvar g = 0; g < 2; g++) begin : lane
        logic [W-2:0] sr;
        logic [CW-1:0] cnt;
        logic [W-1:0] q, word;
        logic vld, ovf, take, last, drain;
        assign word = {sr, bus.i};
        assign take = bus.v && (bus.s == 1'(g));
        assign last = cnt == CW'(W - 1);
        assign drain = vld && rdy[g];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sr <= '0;
                cnt <= '0;
                q <= '0;
                vld <= 1'b0;
                ovf <= 1'b0;
            end else begin
                if (take) begin
                    sr <= word[W-2:0];
                    cnt <= last ? '0 : cnt + 1'b1;
                end
                // a completed word may replace the held one only if it is leaving on this edge
                if (take && last && (!vld || drain)) begin
                    q <= word;
                    vld <= 1'b1;
                end else if (take && last) begin
                    ovf <= 1'b1;
                end else if (drain) begin
                    vld <= 1'b0;
                end
            end
        end
    end
    assign bus.q0 = lane[0].q;
    assign bus.q1 = lane[1].q;
    assign bus.vld0 = lane[0].vld;
    assign bus.vld1 = lane[1].vld;
    assign bus.ovf0 = lane[0].ovf;
    assign bus.ovf1 = lane[1].ovf;
endmodule

// File: tb/tb_demux2_deser.sv
// tb_demux2_deser: word table plus hand-written corner sequences; drained words are checked against per-lane queues.
module tb_demux2_deser;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];

    demux2_deser_if #(.W(8)) bus();
    demux2_deser #(.W(8)) dut(.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic ln;
        logic [7:0] w;
        int gap;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic ln);
        bus.v = 1'b1;
        bus.i = b;
        bus.s = ln;
        tick();
        bus.v = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic ln, input int gap);
        for (int b = 7; b >= 0; b--) begin
            send_bit(w[b], ln);
            repeat (gap) tick();
        end
    endtask

    // a word leaves the holding register on any edge where vld and rdy are both high
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.vld0 && bus.rdy0) begin
                if (exp0.size() == 0) chk("sb0_unexpected", {24'h0, bus.q0}, 32'hFFFF_FFFF);
                else chk("sb0_word", {24'h0, bus.q0}, {24'h0, exp0.pop_front()});
            end
            if (bus.vld1 && bus.rdy1) begin
                if (exp1.size() == 0) chk("sb1_unexpected", {24'h0, bus.q1}, 32'hFFFF_FFFF);
                else chk("sb1_word", {24'h0, bus.q1}, {24'h0, exp1.pop_front()});
            end
        end
    end

    initial begin
        vec_t tbl[6];
        logic [7:0] w;
        logic [7:0] seq;
        tbl = '{'{1'b0, 8'h81, 0}, '{1'b1, 8'h7E, 0}, '{1'b1, 8'hC9, 1},
                '{1'b0, 8'h00, 0}, '{1'b0, 8'h5F, 2}, '{1'b1, 8'hFF, 0}};
        bus.i = 1'b0;
        bus.s = 1'b0;
        bus.v = 1'b0;
        bus.rdy0 = 1'b0;
        bus.rdy1 = 1'b0;
        rst = 1'b1;
        #12;
        chk("rst_q0", {24'h0, bus.q0}, 0);
        chk("rst_q1", {24'h0, bus.q1}, 0);
        chk("rst_flags", {28'h0, bus.vld0, bus.vld1, bus.ovf0, bus.ovf1}, 0);
        rst = 1'b0;
        tick();

        // lane 0 capture, single-cycle valid pulse
        bus.rdy0 = 1'b1;
        bus.rdy1 = 1'b1;
        w = 8'hA5;
        exp0.push_back(w);
        for (int b = 7; b >= 0; b--) begin
            send_bit(w[b], 1'b0);
            chk("cap_vld1_low", {31'h0, bus.vld1}, 0);
            if (b > 0) chk("cap_vld0_early", {31'h0, bus.vld0}, 0);
        end
        chk("cap_q0", {24'h0, bus.q0}, 32'hA5);
        chk("cap_vld0", {31'h0, bus.vld0}, 1);
        chk("cap_ovf0", {31'h0, bus.ovf0}, 0);
        tick();
        chk("cap_vld0_pulse", {31'h0, bus.vld0}, 0);

        // interleaved lanes
        exp0.push_back(8'hFF);
        exp1.push_back(8'h00);
        for (int k = 0; k < 16; k++) begin
            send_bit(~k[0], k[0]);
            if (k == 14) begin
                chk("il_q0", {24'h0, bus.q0}, 32'hFF);
                chk("il_vld0", {31'h0, bus.vld0}, 1);
                chk("il_vld1_early", {31'h0, bus.vld1}, 0);
            end
        end
        chk("il_q1", {24'h0, bus.q1}, 0);
        chk("il_vld1", {31'h0, bus.vld1}, 1);
        tick();

        // word table, drained immediately
        for (int n = 0; n < 6; n++) begin
            if (tbl[n].ln) exp1.push_back(tbl[n].w);
            else exp0.push_back(tbl[n].w);
            send_word(tbl[n].w, tbl[n].ln, tbl[n].gap);
            if (tbl[n].gap == 0) begin
                chk("tbl_q", {24'h0, tbl[n].ln ? bus.q1 : bus.q0}, {24'h0, tbl[n].w});
                chk("tbl_vld", {31'h0, tbl[n].ln ? bus.vld1 : bus.vld0}, 1);
            end
            tick();
        end

        // completion and drain on the same edge
        bus.rdy0 = 1'b0;
        exp0.push_back(8'h11);
        send_word(8'h11, 1'b0, 0);
        chk("sd_q0_hold", {24'h0, bus.q0}, 32'h11);
        w = 8'h22;
        exp0.push_back(w);
        for (int b = 7; b > 0; b--) send_bit(w[b], 1'b0);
        chk("sd_vld0_held", {31'h0, bus.vld0}, 1);
        bus.rdy0 = 1'b1;
        send_bit(w[0], 1'b0);
        chk("sd_q0", {24'h0, bus.q0}, 32'h22);
        chk("sd_vld0", {31'h0, bus.vld0}, 1);
        chk("sd_ovf0", {31'h0, bus.ovf0}, 0);
        tick();
        chk("sd_vld0_drained", {31'h0, bus.vld0}, 0);

        // backpressure overflow
        bus.rdy0 = 1'b0;
        exp0.push_back(8'h3C);
        send_word(8'h3C, 1'b0, 0);
        chk("ov_ovf0_first", {31'h0, bus.ovf0}, 0);
        send_word(8'hC3, 1'b0, 0);
        chk("ov_q0", {24'h0, bus.q0}, 32'h3C);
        chk("ov_vld0", {31'h0, bus.vld0}, 1);
        chk("ov_ovf0", {31'h0, bus.ovf0}, 1);
        chk("ov_ovf1", {31'h0, bus.ovf1}, 0);
        bus.rdy0 = 1'b1;
        tick();
        chk("ov_vld0_drained", {31'h0, bus.vld0}, 0);
        chk("ov_ovf0_sticky", {31'h0, bus.ovf0}, 1);

        // bubbles: outputs must not move on v=0 cycles
        bus.rdy0 = 1'b0;
        w = 8'hA5;
        exp0.push_back(w);
        for (int b = 7; b >= 0; b--) begin
            send_bit(w[b], 1'b0);
            for (int c = 0; c < 3; c++) begin
                tick();
                chk("bub_q0", {24'h0, bus.q0}, b == 0 ? 32'hA5 : 32'h3C);
                chk("bub_vld0", {31'h0, bus.vld0}, b == 0 ? 1 : 0);
            end
        end
        bus.rdy0 = 1'b1;
        tick();
        chk("bub_drained", {31'h0, bus.vld0}, 0);

        // asynchronous reset mid-word
        chk("pre_rst_queues", exp0.size() + exp1.size(), 0);
        seq = 8'hF0;
        for (int b = 7; b >= 4; b--) send_bit(seq[b], 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mr_q0", {24'h0, bus.q0}, 0);
        chk("mr_q1", {24'h0, bus.q1}, 0);
        chk("mr_flags", {28'h0, bus.vld0, bus.vld1, bus.ovf0, bus.ovf1}, 0);
        rst = 1'b0;
        w = 8'h5A;
        exp1.push_back(w);
        for (int b = 7; b >= 0; b--) begin
            send_bit(w[b], 1'b1);
            if (b > 0) chk("mr_vld1_early", {31'h0, bus.vld1}, 0);
        end
        chk("mr_q1_word", {24'h0, bus.q1}, 32'h5A);
        chk("mr_vld1", {31'h0, bus.vld1}, 1);
        repeat (3) tick();
        chk("sb_empty", exp0.size() + exp1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/demux2_deser.md
# demux2_deser

Dual-lane serial-to-parallel collector sitting directly downstream of the 1:2 bit demultiplexer. Each bit on `i` is steered by `s` into lane 0 or lane 1, and each lane assembles its own W-bit word MSB-first. Completed words are presented on per-lane valid/ready outputs with a one-word holding register. Words that arrive while the holding register is occupied are dropped and flagged by a sticky overflow bit.

## Interface
- `W`, default 8: word width per lane; legal range 2..32.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `i`  in  1  serial data bit.
- `s`  in  1  lane select: 0 selects lane 0, 1 selects lane 1.
- `v`  in  1  bit valid; `i` and `s` are sampled only when `v`=1.
- `rdy0`, `rdy1`  in  1 each  consumer ready, lane 0 / lane 1.
- `q0`, `q1`  out  W each  assembled word, lane 0 / lane 1.
- `vld0`, `vld1`  out  1 each  word valid, lane 0 / lane 1.
- `ovf0`, `ovf1`  out  1 each  sticky overflow, lane 0 / lane 1.

## Operation
- Each lane has identical, independent state: shift register `sr` (W-1 bits), bit counter `cnt` (0..W-1, width clog2(W)), holding register `q`, flag `vld`, flag `ovf`.
- Bit accept: on a rising edge with `v`=1, only lane `s` is affected. The other lane's `sr` and `cnt` hold.
- Non-final bit (`cnt` < W-1): `sr` <= {`sr`[W-3:0], `i`}; `cnt` <= `cnt`+1.
- Final bit (`cnt` == W-1): the completed word is {`sr`, `i`} (first bit received is the MSB); `cnt` wraps to 0. `sr` contents after this edge are don't-care.
- Drain: a word is consumed on an edge where `vld`=1 and `rdy`=1.
- Load rule on completion:
  - If `vld`=0, or a drain happens on the same edge: `q` <= the completed word and `vld` <= 1.
  - Otherwise (`vld`=1 and `rdy`=0): the completed word is discarded, `q` and `vld` are unchanged, and `ovf` <= 1.
- Drain without a completion on that edge: `vld` <= 0; `q` holds its value.
- `q` is stable while `vld`=1 and `rdy`=0.
- `ovf` stays at 1 until `rst`. It does not affect collection.
- `v`=0: no state changes except drains.
- `rdy` has no effect while `vld`=0.

## Timing
- Reset: all `sr`, `cnt`, `q0`, `q1`, `vld0`, `vld1`, `ovf0`, `ovf1` are 0, asynchronously on `rst` assertion.
- Reset mid-word: partial bits are discarded. The first accepted bit after reset is the MSB of a new word.
- Latency: `vld` rises and `q` is updated on the same edge that accepts the final bit, so both are visible in the following cycle.
- Throughput: one word per W accepted bits per lane, sustained with `rdy` held at 1 and no bubbles.
- Completion and drain on the same edge: `vld` stays 1, `q` takes the new word, `ovf` does not change.
- Both lanes complete on different edges but drain on the same edge: fully independent, no arbitration.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Lane 0 capture: `v`=1, `s`=0, `i`=1,0,1,0,0,1,0,1 on 8 consecutive edges, `rdy0`=1, W=8.
  - Required: `q0`=8'hA5 and `vld0`=1 for exactly one cycle after the 8th edge.
  - Required: `vld1`=0 throughout and `ovf0`=0.
- Interleaved lanes: 16 bits alternating `s`=0,1. Lane 0 bits form 8'hFF and lane 1 bits form 8'h00.
  - Required: `q0`=8'hFF and `q1`=8'h00, with both `vld` pulses after edge 15 and edge 16 respectively.
- Backpressure overflow: `rdy0`=0; send 8'h3C then 8'hC3 on lane 0.
  - Required: `q0`=8'h3C with `vld0` held at 1, second word lost, `ovf0`=1.
  - Then raise `rdy0`. Required: `vld0`=0 next cycle, `ovf0` still 1.
- Same-edge drain and reload: `vld0`=1 with `q0`=8'h11, `rdy0`=1 on the edge accepting the last bit of 8'h22.
  - Required: `q0`=8'h22, `vld0` stays 1, `ovf0`=0.
- Reset mid-word: 4 bits into lane 1, pulse `rst` asynchronously between edges, then 8 bits forming 8'h5A.
  - Required: all outputs 0 during reset, then `q1`=8'h5A after the 8th post-reset bit.
- Bubbles: same stream as the lane 0 capture test, with `v`=0 inserted for 3 cycles after each bit.
  - Required: `q0`=8'hA5 after the 8th accepted bit. Required: no state change on any `v`=0 cycle.
